// File: rtl/receive_send_buf.sv
// receive_send_buf: lane-transforming valid/ready FIFO buffer (LANES x WIDTH, DEPTH entries).
// Ports: clk, rst_n (async low), in_valid/in_ready/in_data/mode, out_valid/out_ready/out_data,
//        level, stall_cnt; out_parity only when RECEIVE_SEND_BUF_PARITY_EN is defined.
module receive_send_buf #(
    parameter int LANES = 4,
    parameter int WIDTH = 1,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES*WIDTH-1:0]   in_data,
    input  logic [1:0]               mode,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES*WIDTH-1:0]   out_data,
    output logic [$clog2(DEPTH):0]   level,
`ifdef RECEIVE_SEND_BUF_PARITY_EN
    output logic [LANES-1:0]         out_parity,
`endif
    output logic [7:0]               stall_cnt
);

    localparam int W  = LANES * WIDTH;
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [W-1:0]  xf;
    logic [LW-1:0] lvl_nx;
    logic          push;
    logic          pop;

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    // Lane transform applied to the incoming word at accept time.
    always_comb begin
        xf = '0;
        for (int i = 0; i < LANES; i++) begin
            unique case (mode)
                2'b00: xf[i*WIDTH +: WIDTH] = in_data[i*WIDTH +: WIDTH];
                2'b01: xf[i*WIDTH +: WIDTH] = ~in_data[i*WIDTH +: WIDTH];
                2'b10: xf[i*WIDTH +: WIDTH] = in_data[(LANES-1-i)*WIDTH +: WIDTH];
                2'b11: xf[i*WIDTH +: WIDTH] =
                    in_data[((i+LANES-1)%LANES)*WIDTH +: WIDTH];
            endcase
        end
    end

    always_comb begin
        lvl_nx = level;
        if (push && !pop)
            lvl_nx = level + LW'(1);
        else if (pop && !push)
            lvl_nx = level - LW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (push) begin
            mem[wr_ptr] <= xf;
        end
    end

    // Handshake flags are registered from the next level so that
    // out_ready never reaches in_ready combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            level     <= lvl_nx;
            in_ready  <= lvl_nx < LW'(DEPTH);
            out_valid <= lvl_nx != '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt <= '0;
        else if (in_valid && !in_ready && stall_cnt != 8'hFF)
            stall_cnt <= stall_cnt + 8'd1;
    end

    assign out_data = mem[rd_ptr];

`ifdef RECEIVE_SEND_BUF_PARITY_EN
    logic [LANES-1:0] pmem [DEPTH];
    logic [LANES-1:0] xp;

    always_comb begin
        xp = '0;
        for (int i = 0; i < LANES; i++)
            xp[i] = ^xf[i*WIDTH +: WIDTH];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                pmem[i] <= '0;
        end else if (push) begin
            pmem[wr_ptr] <= xp;
        end
    end

    assign out_parity = pmem[rd_ptr];
`endif

endmodule

// File: tb/tb_receive_send_buf.sv
// tb_receive_send_buf: scoreboard bench for receive_send_buf (LANES=4, WIDTH=1, DEPTH=4).
// Stimulus pushes expected words from a lane-array model; a negedge monitor checks pops.
module tb_receive_send_buf;
    localparam int LANES = 4;
    localparam int WIDTH = 1;
    localparam int DEPTH = 4;
    localparam int W     = LANES * WIDTH;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic [1:0]   mode = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_data;
    logic [2:0]   level;
    logic [7:0]   stall_cnt;
`ifdef RECEIVE_SEND_BUF_PARITY_EN
    logic [LANES-1:0] out_parity;
`endif

    typedef struct packed {
        logic [W-1:0]     d;
        logic [LANES-1:0] p;
    } ent_t;

    ent_t exp_q[$];
    ent_t mon_e;
    int   checks = 0;
    int   fails = 0;

    receive_send_buf #(.LANES(LANES), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .mode(mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .level(level),
`ifdef RECEIVE_SEND_BUF_PARITY_EN
        .out_parity(out_parity),
`endif
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    // Model: split into a lane array, permute/invert by index, repack.
    function automatic ent_t ref_xf(logic [W-1:0] d, logic [1:0] m);
        logic [WIDTH-1:0] ln [LANES];
        logic [WIDTH-1:0] o  [LANES];
        ent_t e;
        for (int i = 0; i < LANES; i++) ln[i] = d[i*WIDTH +: WIDTH];
        for (int i = 0; i < LANES; i++) begin
            case (m)
                2'd0: o[i] = ln[i];
                2'd1: o[i] = ~ln[i];
                2'd2: o[i] = ln[LANES-1-i];
                default: o[i] = ln[(i+LANES-1)%LANES];
            endcase
        end
        e = '0;
        for (int i = 0; i < LANES; i++) begin
            e.d[i*WIDTH +: WIDTH] = o[i];
            e.p[i] = ^o[i];
        end
        return e;
    endfunction

    task automatic chk(string n, logic [31:0] a, logic [31:0] e);
        checks++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL pop_unexpected: got %0h expected none", out_data);
            end else begin
                mon_e = exp_q.pop_front();
                chk("out_data", 32'(out_data), 32'(mon_e.d));
`ifdef RECEIVE_SEND_BUF_PARITY_EN
                chk("out_parity", 32'(out_parity), 32'(mon_e.p));
`endif
            end
        end
    end

    task automatic send(logic [W-1:0] d, logic [1:0] m);
        bit acc = 0;
        in_valid = 1'b1;
        in_data  = d;
        mode     = m;
        for (int n = 0; n < 200 && !acc; n++) begin
            acc = in_ready;
            if (acc) exp_q.push_back(ref_xf(d, m));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!acc) begin
            checks++;
            fails++;
            $display("FAIL send_timeout: got no accept expected accept");
        end
    endtask

    task automatic drain();
        int n = 0;
        out_ready = 1'b1;
        while (level != 0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        out_ready = 1'b0;
        chk("drain_level", 32'(level), 0);
    endtask

    initial begin
        logic [7:0] s0;
        bit hold;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_level", 32'(level), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_stall", 32'(stall_cnt), 0);
        chk("rst_out_data", 32'(out_data), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rel_in_ready", 32'(in_ready), 1);

        // modes
        send(4'b0001, 2'b00);
        chk("lat_valid", 32'(out_valid), 1);
        chk("lat_data", 32'(out_data), 32'h1);
        send(4'b0001, 2'b01);
        send(4'b0001, 2'b10);
        send(4'b0001, 2'b11);
        chk("modes_level", 32'(level), 4);
        drain();

        // full / backpressure
        for (int i = 0; i < 4; i++) send(W'(i + 3), 2'b00);
        chk("full_level", 32'(level), 4);
        chk("full_in_ready", 32'(in_ready), 0);
        in_valid = 1'b1;
        in_data  = 4'b1010;
        mode     = 2'b00;
        s0 = stall_cnt;
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("stall_inc", 32'(stall_cnt), 32'(s0 + 8'd3));
        chk("held_in_ready", 32'(in_ready), 0);
        chk("held_level", 32'(level), 4);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("pop_level", 32'(level), 3);
        chk("pop_in_ready", 32'(in_ready), 1);
        exp_q.push_back(ref_xf(in_data, mode));
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("fifth_level", 32'(level), 4);
        drain();

        // simultaneous push/pop across pointer wrap
        send(4'b1100, 2'b00);
        send(4'b0110, 2'b11);
        chk("sim_level0", 32'(level), 2);
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            send(W'($urandom), 2'($urandom));
            chk("sim_level", 32'(level), 2);
        end
        drain();

        // randomized traffic, sender holds a refused word
        hold = 0;
        repeat (300) begin
            if (!hold) begin
                in_valid = 1'($urandom_range(0, 1));
                in_data  = W'($urandom);
                mode     = 2'($urandom);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            if (in_valid && in_ready) exp_q.push_back(ref_xf(in_data, mode));
            hold = in_valid && !in_ready;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        drain();

        // reset mid-stream with 3 words held
        send(4'b1001, 2'b00);
        send(4'b0011, 2'b01);
        send(4'b0101, 2'b10);
        chk("pre_rst_level", 32'(level), 3);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("mid_rst_level", 32'(level), 0);
        chk("mid_rst_valid", 32'(out_valid), 0);
        chk("mid_rst_in_ready", 32'(in_ready), 0);
        chk("mid_rst_stall", 32'(stall_cnt), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("rel2_in_ready_lo", 32'(in_ready), 0);
        @(posedge clk); #1;
        chk("rel2_in_ready_hi", 32'(in_ready), 1);
        chk("rel2_out_valid", 32'(out_valid), 0);

        // stall counter saturation
        for (int i = 0; i < 4; i++) send(W'(i), 2'b01);
        in_valid = 1'b1;
        in_data  = 4'b1111;
        repeat (100) begin
            @(posedge clk); #1;
        end
        chk("stall_100", 32'(stall_cnt), 100);
        repeat (200) begin
            @(posedge clk); #1;
        end
        chk("stall_sat", 32'(stall_cnt), 255);
        in_valid = 1'b0;
        drain();

`ifdef RECEIVE_SEND_BUF_PARITY_EN
        send(4'b0111, 2'b00);
        send(4'b0111, 2'b01);
        chk("par_m0", 32'(out_parity), 32'h7);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("par_m1", 32'(out_parity), 32'h8);
        drain();
`endif

        chk("sb_empty", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
